// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI response arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2
    } arb_state_e;

    localparam int unsigned SPI_ARB_MAX_REQ = 8;
    localparam int unsigned SPI_ARB_CNT_W   = 8;

    function automatic logic [SPI_ARB_CNT_W-1:0] sat_inc(input logic [SPI_ARB_CNT_W-1:0] v);
        return (v == '1) ? v : v + SPI_ARB_CNT_W'(1);
    endfunction

endpackage

// File: rtl/spi_arb_priority_encoder.sv
// Lowest-index-wins one-hot grant over the requester valids, plus a multiple-valid flag.
module spi_arb_priority_encoder #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant,
    output logic               any_valid,
    output logic               multi_valid
);

    always_comb begin
        // x & -x isolates the lowest set bit
        grant       = valid & (~valid + NUM_REQ'(1));
        any_valid   = |valid;
        multi_valid = |(valid & ~grant);
    end

endmodule

// File: rtl/spi_response_arbiter.sv
// Arbitrates the SPI response path between NUM_REQ blocks per transaction.
// Optional SPI_ARB_STATUS_EN: STATUS_OPCODE returns a saturating collision+timeout count.
module spi_response_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ          = 3,
    parameter int unsigned TIMEOUT_CYCLES   = 64,
    parameter logic [7:0]  DEFAULT_RESPONSE = 8'h00,
    parameter logic [7:0]  STATUS_OPCODE    = 8'hDC
) (
    input  logic                    clock_in,
    input  logic                    reset_in,
    input  logic [7:0]              opcode_in,
    input  logic                    opcode_valid_in,
    input  logic [NUM_REQ-1:0][7:0] response_in,
    input  logic [NUM_REQ-1:0]      response_valid_in,
    output logic [7:0]              response_out,
    output logic                    response_valid_out,
    output logic [NUM_REQ-1:0]      grant_out,
    output logic                    collision_out,
    output logic                    timeout_out
);

    localparam int unsigned        TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

    arb_state_e         state_q;
    logic [TIMER_W-1:0] timer_q;
    logic               opcode_valid_q;
    logic [7:0]         resp_q;
    logic               resp_valid_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               collision_q;
    logic               timeout_q;

    logic [NUM_REQ-1:0] pe_grant;
    logic               pe_any;
    logic               pe_multi;
    logic [7:0]         win_byte;
    logic [7:0]         own_byte;
    logic               own_valid;

`ifdef SPI_ARB_STATUS_EN
    logic [SPI_ARB_CNT_W-1:0] status_cnt_q;
`else
    logic unused_opcode;
    assign unused_opcode = ^opcode_in;
`endif

    spi_arb_priority_encoder #(
        .NUM_REQ(NUM_REQ)
    ) u_prio (
        .valid      (response_valid_in),
        .grant      (pe_grant),
        .any_valid  (pe_any),
        .multi_valid(pe_multi)
    );

    always_comb begin
        win_byte = '0;
        own_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pe_grant[i]) win_byte = win_byte | response_in[i];
            if (grant_q[i])  own_byte = own_byte | response_in[i];
        end
        own_valid = |(grant_q & response_valid_in);
    end

    always_ff @(posedge clock_in) begin
        // Tracked through reset so a level already high after reset is not taken as a rise
        opcode_valid_q <= opcode_valid_in;
        if (reset_in) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            grant_q      <= '0;
            collision_q  <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef SPI_ARB_STATUS_EN
            status_cnt_q <= '0;
`endif
        end else if (!opcode_valid_in) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            grant_q      <= '0;
            collision_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            collision_q <= 1'b0;
            timeout_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!opcode_valid_q) begin
                        state_q <= StWait;
                        timer_q <= '0;
                    end
                end
                StWait: begin
                    if (timer_q != TIMER_MAX) timer_q <= timer_q + TIMER_W'(1);
`ifdef SPI_ARB_STATUS_EN
                    if (opcode_in == STATUS_OPCODE) begin
                        resp_q       <= status_cnt_q;
                        resp_valid_q <= 1'b1;
                        grant_q      <= '0;
                        state_q      <= StHold;
                    end else
`endif
                    if (pe_any) begin
                        resp_q       <= win_byte;
                        resp_valid_q <= 1'b1;
                        grant_q      <= pe_grant;
                        collision_q  <= pe_multi;
                        state_q      <= StHold;
`ifdef SPI_ARB_STATUS_EN
                        if (pe_multi) status_cnt_q <= sat_inc(status_cnt_q);
`endif
                    end else if (timer_q == TIMER_LAST) begin
                        resp_q       <= DEFAULT_RESPONSE;
                        resp_valid_q <= 1'b1;
                        grant_q      <= '0;
                        timeout_q    <= 1'b1;
                        state_q      <= StHold;
`ifdef SPI_ARB_STATUS_EN
                        status_cnt_q <= sat_inc(status_cnt_q);
`endif
                    end
                end
                StHold: begin
                    // No owner after timeout or status reply, so the byte stays put
                    if (own_valid) resp_q <= own_byte;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign response_out       = resp_q;
    assign response_valid_out = resp_valid_q;
    assign grant_out          = grant_q;
    assign collision_out      = collision_q;
    assign timeout_out        = timeout_q;

endmodule

// File: tb/tb_spi_response_arbiter.sv
// Scoreboard bench for spi_response_arbiter (NUM_REQ=3, TIMEOUT_CYCLES=64).
module tb_spi_response_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      opcode;
    logic            opcode_valid;
    logic [2:0][7:0] response;
    logic [2:0]      response_valid;
    logic [7:0]      response_out;
    logic            response_valid_out;
    logic [2:0]      grant_out;
    logic            collision_out;
    logic            timeout_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] resp;
        logic       vld;
        logic [2:0] gnt;
        logic       coll;
        logic       to;
    } exp_t;

    exp_t sb_q[$];

    spi_response_arbiter #(
        .NUM_REQ         (3),
        .TIMEOUT_CYCLES  (64),
        .DEFAULT_RESPONSE(8'h00),
        .STATUS_OPCODE   (8'hDC)
    ) dut (
        .clock_in          (clk),
        .reset_in          (rst),
        .opcode_in         (opcode),
        .opcode_valid_in   (opcode_valid),
        .response_in       (response),
        .response_valid_in (response_valid),
        .response_out      (response_out),
        .response_valid_out(response_valid_out),
        .grant_out         (grant_out),
        .collision_out     (collision_out),
        .timeout_out       (timeout_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] resp, input logic vld,
                              input logic [2:0] gnt, input logic coll, input logic to);
        exp_t e;
        e.tag  = tag;
        e.resp = resp;
        e.vld  = vld;
        e.gnt  = gnt;
        e.coll = coll;
        e.to   = to;
        sb_q.push_back(e);
    endtask

    // Advance one edge, then compare whatever the stimulus queued for this edge
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq({e.tag, ".resp"},  32'(response_out),       32'(e.resp));
            check_eq({e.tag, ".valid"}, 32'(response_valid_out), 32'(e.vld));
            check_eq({e.tag, ".grant"}, 32'(grant_out),          32'(e.gnt));
            check_eq({e.tag, ".coll"},  32'(collision_out),      32'(e.coll));
            check_eq({e.tag, ".tmo"},   32'(timeout_out),        32'(e.to));
        end
    endtask

    task automatic set_req(input int idx, input logic [7:0] b, input logic v);
        response[idx]       = b;
        response_valid[idx] = v;
    endtask

    task automatic end_txn();
        opcode_valid   = 1'b0;
        response_valid = '0;
        expect_out("end", 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
    endtask

    task automatic start_txn(input logic [7:0] op);
        opcode       = op;
        opcode_valid = 1'b1;
        expect_out("rise", 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        rst            = 1'b1;
        opcode         = 8'h00;
        opcode_valid   = 1'b0;
        response       = '0;
        response_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        expect_out("reset", 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();

        // 1: req2 valid at cycle 3, output at cycle 4
        start_txn(8'hDB);
        expect_out("t1.c2", 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        set_req(2, 8'h81, 1'b1);
        expect_out("t1.grant", 8'h81, 1'b1, 3'b100, 1'b0, 1'b0);
        tick();
        set_req(2, 8'h81, 1'b0);
        expect_out("t1.hold", 8'h81, 1'b1, 3'b100, 1'b0, 1'b0);
        tick();
        end_txn();

        // 2: simultaneous req0/req1
        start_txn(8'hDB);
        set_req(0, 8'h11, 1'b1);
        set_req(1, 8'h22, 1'b1);
        expect_out("t2.coll", 8'h11, 1'b1, 3'b001, 1'b1, 1'b0);
        tick();
        expect_out("t2.pulse", 8'h11, 1'b1, 3'b001, 1'b0, 1'b0);
        tick();
        end_txn();

        // 3: timeout at edge 64 after the rise, not at 63
        start_txn(8'hDB);
        for (int i = 1; i < 63; i++) tick();
        expect_out("t3.early", 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        expect_out("t3.tmo", 8'h00, 1'b1, 3'b000, 1'b0, 1'b1);
        tick();
        set_req(1, 8'h55, 1'b1);
        expect_out("t3.ign", 8'h00, 1'b1, 3'b000, 1'b0, 1'b0);
        tick();
        expect_out("t3.ign2", 8'h00, 1'b1, 3'b000, 1'b0, 1'b0);
        tick();
        end_txn();

        // 6: status opcode after one collision and one timeout
        start_txn(8'hDC);
        set_req(0, 8'h44, 1'b1);
`ifdef SPI_ARB_STATUS_EN
        expect_out("t6.status", 8'h02, 1'b1, 3'b000, 1'b0, 1'b0);
`else
        expect_out("t6.plain", 8'h44, 1'b1, 3'b001, 1'b0, 1'b0);
`endif
        tick();
        end_txn();

        // 4: req1 owns and streams while req0 toggles
        start_txn(8'hDB);
        set_req(1, 8'hA0, 1'b1);
        expect_out("t4.a0", 8'hA0, 1'b1, 3'b010, 1'b0, 1'b0);
        tick();
        set_req(1, 8'hA1, 1'b1);
        set_req(0, 8'h5A, 1'b1);
        expect_out("t4.a1", 8'hA1, 1'b1, 3'b010, 1'b0, 1'b0);
        tick();
        set_req(1, 8'hA2, 1'b1);
        set_req(0, 8'h5A, 1'b0);
        expect_out("t4.a2", 8'hA2, 1'b1, 3'b010, 1'b0, 1'b0);
        tick();
        set_req(1, 8'hA3, 1'b0);
        set_req(0, 8'h77, 1'b1);
        expect_out("t4.held", 8'hA2, 1'b1, 3'b010, 1'b0, 1'b0);
        tick();
        end_txn();

        // 5a: opcode drop wins over a same-cycle grant
        start_txn(8'hDB);
        opcode_valid = 1'b0;
        set_req(0, 8'h33, 1'b1);
        expect_out("t5.drop", 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        expect_out("t5.idle", 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        response_valid = '0;

        // 5b: reset in HOLD with opcode held high stays idle until a new rise
        start_txn(8'hDB);
        set_req(0, 8'h33, 1'b1);
        expect_out("t5.own", 8'h33, 1'b1, 3'b001, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        expect_out("t5.rst", 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        expect_out("t5.norise1", 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        expect_out("t5.norise2", 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        end_txn();
        start_txn(8'hDB);
        set_req(0, 8'h3C, 1'b1);
        expect_out("t5.again", 8'h3C, 1'b1, 3'b001, 1'b0, 1'b0);
        tick();
        end_txn();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
